// File: rtl/lsu_split_access_pkg.sv
// Shared types for the split-access LSU: DMType codes, FSM states
// and the size-from-type mapping. Optional macro: LSU_ALIGN_EXC_EN.
package lsu_split_access_pkg;

    localparam logic [2:0] dm_word          = 3'd0;
    localparam logic [2:0] dm_half          = 3'd1;
    localparam logic [2:0] dm_half_unsigned = 3'd2;
    localparam logic [2:0] dm_byte          = 3'd3;
    localparam logic [2:0] dm_byte_unsigned = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A0,
        S_A1,
        S_LAST,
        S_RESP
    } lsu_state_e;

    // Access size in bytes; illegal codes map to 4 but are never issued.
    function automatic logic [2:0] dm_size(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            dm_half, dm_half_unsigned: s = 3'd2;
            dm_byte, dm_byte_unsigned: s = 3'd1;
            default:                   s = 3'd4;
        endcase
        return s;
    endfunction

    function automatic logic dm_legal(input logic [2:0] t);
        return t <= dm_byte_unsigned;
    endfunction

endpackage

// File: rtl/lsu_split_access_if.sv
// Bus bundle of the LSU: request, SRAM and response channels.
// slave = LSU side, master = pipeline/SRAM side.
interface lsu_split_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              sram_en;
    logic [3:0]        sram_wea;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_store, req_type, req_addr, req_wdata,
        input  sram_rdata, resp_ready,
        output req_ready, sram_en, sram_wea, sram_addr, sram_wdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_store, req_type, req_addr, req_wdata,
        output sram_rdata, resp_ready,
        input  req_ready, sram_en, sram_wea, sram_addr, sram_wdata,
        input  resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: write masks/data for both word halves, and the
// 64-bit read merge, shift and sign/zero extension.
module lsu_lane_align
    import lsu_split_access_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    input  logic [2:0]  dm_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd_lo_i,
    input  logic [31:0] rd_hi_i,
    output logic [3:0]  wea0_o,
    output logic [3:0]  wea1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] rdata_o
);
    logic [3:0]  smask;
    logic [7:0]  lanes;
    logic [63:0] wshift;
    logic [63:0] merged;
    logic [31:0] bytes;

    always_comb begin
        smask = 4'b1111;
        case (size_i)
            3'd1:    smask = 4'b0001;
            3'd2:    smask = 4'b0011;
            default: smask = 4'b1111;
        endcase
    end

    // Lanes past byte 3 spill into the next word.
    assign lanes    = {4'b0000, smask} << off_i;
    assign wea0_o   = lanes[3:0];
    assign wea1_o   = lanes[7:4];

    assign wshift   = {32'h0, wdata_i} << {off_i, 3'b000};
    assign wdata0_o = wshift[31:0];
    assign wdata1_o = wshift[63:32];

    assign merged   = {rd_hi_i, rd_lo_i};
    assign bytes    = merged[{off_i, 3'b000} +: 32];

    always_comb begin
        rdata_o = bytes;
        case (dm_i)
            dm_half:          rdata_o = {{16{bytes[15]}}, bytes[15:0]};
            dm_half_unsigned: rdata_o = {16'h0, bytes[15:0]};
            dm_byte:          rdata_o = {{24{bytes[7]}}, bytes[7:0]};
            dm_byte_unsigned: rdata_o = {24'h0, bytes[7:0]};
            default:          rdata_o = bytes;
        endcase
    end

endmodule

// File: rtl/lsu_split_access.sv
// Load/store unit between EX/MEM and a synchronous SRAM; splits
// word-crossing accesses in two. Ports: clk, rstn, bus (slave).
// Macro LSU_ALIGN_EXC_EN: misaligned accesses return resp_err.
module lsu_split_access
    import lsu_split_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clk,
    input logic               rstn,
    lsu_split_access_if.slave bus
);
    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        dm_q, dm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cross_q, cross_d;
    logic [DATA_W-1:0] word0_q, word0_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        req_off;
    logic [2:0]        req_size;
    logic              req_cross;
    logic              req_bad;

    logic [ADDR_W-3:0] wa, wa_nxt;
    logic [3:0]        wea0, wea1;
    logic [DATA_W-1:0] wd0, wd1;
    logic [DATA_W-1:0] rd_lo, ld_data;

    assign req_off   = bus.req_addr[1:0];
    assign req_size  = dm_size(bus.req_type);
    assign req_cross = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;

`ifdef LSU_ALIGN_EXC_EN
    assign req_bad = !dm_legal(bus.req_type) ||
                     ((req_off & (req_size[1:0] - 2'd1)) != 2'd0);
`else
    assign req_bad = !dm_legal(bus.req_type);
`endif

    assign wa     = addr_q[ADDR_W-1:2];
    assign wa_nxt = wa + {{(ADDR_W-3){1'b0}}, 1'b1};

    // Crossing loads merge the A1-captured word with the live one.
    assign rd_lo  = cross_q ? word0_q : bus.sram_rdata;

    lsu_lane_align u_align (
        .off_i    (addr_q[1:0]),
        .size_i   (dm_size(dm_q)),
        .dm_i     (dm_q),
        .wdata_i  (wdata_q),
        .rd_lo_i  (rd_lo),
        .rd_hi_i  (bus.sram_rdata),
        .wea0_o   (wea0),
        .wea1_o   (wea1),
        .wdata0_o (wd0),
        .wdata1_o (wd1),
        .rdata_o  (ld_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
            dm_q    <= dm_word;
            addr_q  <= '0;
            wdata_q <= '0;
            cross_q <= 1'b0;
            word0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            dm_q    <= dm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cross_q <= cross_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        dm_d    = dm_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cross_d = cross_q;
        word0_d = word0_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    store_d = bus.req_store;
                    dm_d    = bus.req_type;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cross_d = req_cross;
                    rdata_d = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? S_RESP : S_A0;
                end
            end
            S_A0: state_d = cross_q ? S_A1 : S_LAST;
            S_A1: begin
                if (!store_q) word0_d = bus.sram_rdata;
                state_d = S_LAST;
            end
            S_LAST: begin
                rdata_d = store_q ? '0 : ld_data;
                state_d = S_RESP;
            end
            S_RESP: if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.sram_en    = 1'b0;
        bus.sram_wea   = 4'b0000;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        case (state_q)
            S_A0: begin
                bus.sram_en   = 1'b1;
                bus.sram_addr = {wa, 2'b00};
                if (store_q) begin
                    bus.sram_wea   = wea0;
                    bus.sram_wdata = wd0;
                end
            end
            S_A1: begin
                bus.sram_en   = 1'b1;
                bus.sram_addr = {wa_nxt, 2'b00};
                if (store_q) begin
                    bus.sram_wea   = wea1;
                    bus.sram_wdata = wd1;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_split_access.sv
// Scoreboard bench for lsu_split_access: directed loads/stores,
// split accesses, wrap, backpressure, illegal type and reset.
module tb_lsu_split_access;
    import lsu_split_access_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wea;
        logic [31:0] wdata;
    } sram_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    sram_exp_t sq[$];
    resp_exp_t rq[$];
    logic [31:0] mem [logic [31:0]];

    lsu_split_access_if #(.ADDR_W(32), .DATA_W(32)) bus();

    lsu_split_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got event want none", nm);
    endtask

    // Synchronous SRAM: read data one cycle after the strobe.
    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.sram_en) begin
            w = mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : 32'h0;
            bus.sram_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (bus.sram_wea[b]) w[8*b +: 8] = bus.sram_wdata[8*b +: 8];
            mem[bus.sram_addr] = w;
        end
    end

    always @(negedge clk) begin
        sram_exp_t e;
        if (bus.sram_en) begin
            if (sq.size() == 0) bad("sram_unexpected");
            else begin
                e = sq.pop_front();
                chk("sram_addr", bus.sram_addr, e.addr);
                chk("sram_wea", bus.sram_wea, e.wea);
                if (e.wea != 4'h0) chk("sram_wdata", bus.sram_wdata, e.wdata);
            end
        end
    end

    int first_cyc = 0;
    bit seen = 1'b0;
    always @(negedge clk) begin
        resp_exp_t e;
        if (bus.resp_valid && !seen) begin
            seen = 1'b1;
            first_cyc = cyc;
        end
        if (bus.resp_valid && bus.resp_ready) begin
            seen = 1'b0;
            if (rq.size() == 0) bad("resp_unexpected");
            else begin
                e = rq.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_err", bus.resp_err, e.err);
                chk("resp_latency", first_cyc - e.acc, e.lat);
            end
        end
    end

    task automatic sx(input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd);
        sq.push_back('{addr: a, wea: we, wdata: wd});
    endtask

    // lat counts edges from accept to first resp_valid (spec latency - 1).
    task automatic issue(input bit st, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input bit ee,
                         input int el, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bad("req_ready_timeout");
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_type  = ty;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (track) rq.push_back('{rdata: er, err: ee, lat: el, acc: cyc});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || sq.size() != 0 || !bus.req_ready)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) bad("drain_timeout");
    endtask

    task automatic rst_chk(input string p);
        chk({p, "_req_ready"}, bus.req_ready, 1);
        chk({p, "_sram_en"}, bus.sram_en, 0);
        chk({p, "_sram_wea"}, bus.sram_wea, 0);
        chk({p, "_sram_addr"}, bus.sram_addr, 0);
        chk({p, "_sram_wdata"}, bus.sram_wdata, 0);
        chk({p, "_resp_valid"}, bus.resp_valid, 0);
        chk({p, "_resp_rdata"}, bus.resp_rdata, 0);
        chk({p, "_resp_err"}, bus.resp_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_exp;
        int n;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_type   = dm_word;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        bus.sram_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        rst_chk("reset");

        sx(32'h100, 4'hF, 32'hDEADBEEF);
        issue(1, dm_word, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_word, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1);
        sx(32'h100, 4'hF, 32'h80123456);
        issue(1, dm_word, 32'h100, 32'h80123456, 32'h0, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_byte, 32'h103, 32'h0, 32'hFFFFFF80, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_byte_unsigned, 32'h103, 32'h0, 32'h00000080, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_half, 32'h102, 32'h0, 32'hFFFF8012, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_half_unsigned, 32'h102, 32'h0, 32'h00008012, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_byte, 32'h100, 32'h0, 32'h00000056, 0, 2, 1);
        sx(32'h100, 4'b0010, 32'hFFFFA500);
        issue(1, dm_byte, 32'h101, 32'hFFFFFFA5, 32'h0, 0, 2, 1);
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_word, 32'h100, 32'h0, 32'h8012A556, 0, 2, 1);
        sx(32'h200, 4'hF, 32'h11223344);
        issue(1, dm_word, 32'h200, 32'h11223344, 32'h0, 0, 2, 1);
        sx(32'h204, 4'hF, 32'h55667788);
        issue(1, dm_word, 32'h204, 32'h55667788, 32'h0, 0, 2, 1);

`ifndef LSU_ALIGN_EXC_EN
        sx(32'h200, 4'b1000, 32'h34000000);
        sx(32'h204, 4'b0001, 32'h00000012);
        issue(1, dm_half, 32'h203, 32'h00001234, 32'h0, 0, 3, 1);
        sx(32'h200, 4'h0, 32'h0);
        sx(32'h204, 4'h0, 32'h0);
        issue(0, dm_half_unsigned, 32'h203, 32'h0, 32'h00001234, 0, 3, 1);
        sx(32'h200, 4'h0, 32'h0);
        sx(32'h204, 4'h0, 32'h0);
        issue(0, dm_word, 32'h202, 32'h0, 32'h77123422, 0, 3, 1);
        sx(32'hFFFFFFFC, 4'hF, 32'hAABBCCDD);
        issue(1, dm_word, 32'hFFFFFFFC, 32'hAABBCCDD, 32'h0, 0, 2, 1);
        sx(32'h0, 4'hF, 32'h01020304);
        issue(1, dm_word, 32'h0, 32'h01020304, 32'h0, 0, 2, 1);
        sx(32'hFFFFFFFC, 4'h0, 32'h0);
        sx(32'h0, 4'h0, 32'h0);
        issue(0, dm_word, 32'hFFFFFFFE, 32'h0, 32'h0304AABB, 0, 3, 1);
        sx(32'h100, 4'b1110, 32'hFEF00D00);
        sx(32'h104, 4'b0001, 32'h000000CA);
        issue(1, dm_word, 32'h101, 32'hCAFEF00D, 32'h0, 0, 3, 1);
        sx(32'h100, 4'h0, 32'h0);
        sx(32'h104, 4'h0, 32'h0);
        issue(0, dm_word, 32'h101, 32'h0, 32'hCAFEF00D, 0, 3, 1);
        bp_exp = 32'hFEF00D56;
`else
        issue(0, dm_word, 32'h102, 32'h0, 32'h0, 1, 0, 1);
        issue(1, dm_half, 32'h203, 32'h1234, 32'h0, 1, 0, 1);
        bp_exp = 32'h8012A556;
`endif

        issue(0, 3'd6, 32'h100, 32'h0, 32'h0, 1, 0, 1);
        issue(1, 3'd7, 32'h100, 32'h5A5A5A5A, 32'h0, 1, 0, 1);

        drain();
        bus.resp_ready = 1'b0;
        sx(32'h100, 4'h0, 32'h0);
        issue(0, dm_word, 32'h100, 32'h0, bp_exp, 0, 2, 1);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", bus.resp_valid, 1);
            chk("bp_resp_rdata", bus.resp_rdata, bp_exp);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;

`ifndef LSU_ALIGN_EXC_EN
        drain();
        sx(32'h200, 4'h0, 32'h0);
        issue(0, dm_half_unsigned, 32'h203, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        rst_chk("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_idle_ready", bus.req_ready, 1);
        sx(32'h200, 4'h0, 32'h0);
        issue(0, dm_word, 32'h200, 32'h0, 32'h34223344, 0, 2, 1);
`endif

        drain();
        chk("sram_queue_empty", sq.size(), 0);
        chk("resp_queue_empty", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_split_access.md
Name: lsu_split_access

Overview:
- Sequential memory-access controller between the EX/MEM pipeline register and the synchronous data SRAM.
- Accepts one load/store request at a time through a valid/ready handshake.
- Generates byte-lane write enables, shifted write data and word-aligned SRAM addresses; the SRAM returns read data one cycle after the access.
- Splits any access that crosses a word boundary into two SRAM accesses. Returns sign- or zero-extended load data through a valid/ready response.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data/SRAM word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_type  in  3  DMType: 0 word, 1 half, 2 half-unsigned, 3 byte, 4 byte-unsigned.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- sram_en  out  1  SRAM access strobe.
- sram_wea  out  4  per-byte write enable; 0 for reads.
- sram_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- sram_wdata  out  DATA_W  lane-shifted write data.
- sram_rdata  in  DATA_W  read data, valid the cycle after sram_en.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  illegal req_type, or misaligned access when ALIGN_EXC_EN is defined.

Behaviour:
- Reset values: state IDLE; req_ready=1; sram_en=0; sram_wea=0; sram_addr=0; sram_wdata=0; resp_valid=0; resp_rdata=0; resp_err=0.
- Reset asserted mid-operation drops the in-flight request immediately; no further sram_en is issued.
- Size: 4 bytes for type 0, 2 for types 1/2, 1 for types 3/4. off = addr[1:0]. cross = (off + size > 4).
- Request capture: only in IDLE (req_ready=1). On req_valid&&req_ready the block registers store, type, addr, wdata, off and cross.
- Illegal type (5–7): no SRAM access; go to RESP next cycle with resp_err=1, resp_rdata=0.
- States: IDLE, A0, A1, LAST, RESP.
  - IDLE→A0 on accept.
  - A0: sram_en=1, sram_addr={addr[ADDR_W-1:2],00}. Store: wea = lanes off..min(off+size-1,3); wdata = req_wdata << 8*off. Next state: A1 if cross, else LAST.
  - A1: sram_en=1, sram_addr = word address + 4, mod 2^ADDR_W (0xFFFFFFFC wraps to 0). Store: wea = lanes 0..off+size-5; wdata = req_wdata >> 8*(4-off). Load: capture sram_rdata as word0. Next state LAST.
  - LAST: sram_en=0. Load: capture sram_rdata as word1 if cross, else as word0. Next state RESP.
  - RESP: resp_valid=1; outputs held stable until resp_ready. RESP→IDLE on resp_ready.
- Latency, accept cycle T to first resp_valid cycle: T+3 without crossing, T+4 with crossing.
- Load data: bytes = ({word1,word0} >> 8*off)[31:0], then extended per type: half → sign-extend bit15; byte → sign-extend bit7; unsigned types → zero-extend.
- Stores respond too (resp_rdata=0) so the pipeline retires on a single handshake.
- resp_ready held high while in IDLE has no effect. No new request is accepted in the same cycle a response completes; req_ready rises the cycle after.

Optional Feature:
- LSU_ALIGN_EXC_EN defined: any access with addr not a multiple of size is not issued to SRAM. The block goes IDLE→RESP at T+1 with resp_err=1, resp_rdata=0; cross is never used.
- Undefined: misaligned accesses are fully supported, and word-crossing accesses are split as described above.

Decomposition:
- Shared header, alongside the existing ctrl/bus defines: DMType encodings (dm_word … dm_byte_unsigned), state encodings, and a size-from-type constant mapping.
- One natural combinational sub-module, lsu_lane_align: lane-mask generation, write-data shift for both halves, and the 64-bit merge, shift and extension on read.

Test Plan:
- Aligned word store addr 0x100, data 0xDEADBEEF → A0 wea=1111, sram_addr 0x100, then word load from 0x100 returns 0xDEADBEEF at T+3.
- Byte load type 3 at 0x103, memory word 0x80xxxxxx → resp_rdata=0xFFFFFF80. Same access with type 4 → 0x00000080.
- Crossing half store addr 0x203, data 0x1234 → A0: addr 0x200, wea=1000, byte 0x34; A1: addr 0x204, wea=0001, byte 0x12. Half-unsigned load from 0x203 → 0x00001234 at T+4.
- Crossing word load at 0xFFFFFFFE → second access wraps to sram_addr 0x00000000; merged bytes are correct.
- Backpressure and reset: resp_ready low for 5 cycles → resp_valid and data held, req_ready=0. rstn pulsed low during A1 → all outputs return to reset values and no further sram_en.
- req_type=6 → no sram_en, resp_err=1 at T+1. With LSU_ALIGN_EXC_EN, word load at 0x102 → resp_err=1, no sram_en.
